// File: rtl/cla_acc_pkg.sv
// Shared types and elaboration helpers for the CLA stream accumulator.
package cla_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_t;

    // Operands are zero-extended into the accumulator, so it must be at least as wide.
    function automatic bit acc_width_ok(input int width, input int acc_width);
        return acc_width >= width;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned carry-lookahead adder; o_result[WIDTH] is the carry-out.
module carry_lookahead_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             chain;

    assign gen  = i_add1 & i_add2;
    assign prop = i_add1 ^ i_add2;

    // Every carry is a flat sum-of-products of generate/propagate terms (no ripple).
    always_comb begin
        carry = '0;
        chain = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                chain = 1'b1;
                for (int k = j + 1; k <= i; k++) begin
                    chain = chain & prop[k];
                end
                carry[i+1] = carry[i+1] | (gen[j] & chain);
            end
        end
    end

    assign o_result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_stream_accumulator.sv
// Reduces each valid/ready burst of operands to one registered sum with
// sticky overflow and a saturating beat count, held until downstream accepts.
module cla_stream_accumulator
    import cla_acc_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int ACC_WIDTH = 5,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_overflow,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam bit WIDTH_OK = acc_width_ok(WIDTH, ACC_WIDTH);

    acc_state_t           state_q;
    acc_state_t           state_d;
    logic                 accept;
    logic                 in_idle;

    logic [ACC_WIDTH-1:0] add1;
    logic [ACC_WIDTH-1:0] add2;
    logic [ACC_WIDTH:0]   add_res;

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_acc_q;
    logic [CNT_WIDTH-1:0] cnt_acc_q;
    logic                 ovf_next;
    logic [CNT_WIDTH-1:0] cnt_next;

    logic [ACC_WIDTH-1:0] sum_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = i_valid && o_ready;

    // Starting a burst from IDLE feeds zero instead of the stale accumulator.
    assign add1 = in_idle ? '0 : acc_q;
    assign add2 = WIDTH_OK ? ACC_WIDTH'(i_data) : '0;

    carry_lookahead_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .i_add1   (add1),
        .i_add2   (add2),
        .o_result (add_res)
    );

    assign ovf_next = (in_idle ? 1'b0 : ovf_acc_q) | add_res[ACC_WIDTH];
    assign cnt_next = in_idle ? CNT_WIDTH'(1) : sat_inc(cnt_acc_q);

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                o_ready = 1'b1;
                if (accept) begin
                    state_d = i_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Running totals update on every beat; the result copy only on the closing beat,
    // so the presented result survives while the next burst accumulates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_acc_q <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            acc_q     <= add_res[ACC_WIDTH-1:0];
            ovf_acc_q <= ovf_next;
            cnt_acc_q <= cnt_next;
            if (i_last) begin
                sum_q <= add_res[ACC_WIDTH-1:0];
                ovf_q <= ovf_next;
                cnt_q <= cnt_next;
            end
        end
    end

    assign o_sum      = sum_q;
    assign o_overflow = ovf_q;
    assign o_count    = cnt_q;

endmodule

// File: tb/tb_cla_stream_accumulator.sv
// Randomized and directed bench for cla_stream_accumulator against a burst-level sum model.
module tb_cla_stream_accumulator;

    localparam int WIDTH     = 3;
    localparam int ACC_WIDTH = 5;
    localparam int CNT_WIDTH = 4;
    localparam int SUM_MOD   = 1 << ACC_WIDTH;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 i_clk   = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 i_last  = 1'b0;
    logic                 i_ready = 1'b0;
    logic [WIDTH-1:0]     i_data  = '0;
    logic                 o_ready;
    logic                 o_valid;
    logic [ACC_WIDTH-1:0] o_sum;
    logic                 o_overflow;
    logic [CNT_WIDTH-1:0] o_count;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned burst_q[$];

    cla_stream_accumulator #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sum      (o_sum),
        .o_overflow (o_overflow),
        .o_count    (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Entry and exit point: just after a falling edge. Drives burst_q, checks the
    // result against the plain-arithmetic sum, optionally stalls, then releases.
    // next_beat >= 0 keeps an upstream beat (last=1) pending throughout HOLD.
    task automatic run_burst(input int hold, input int next_beat, input bit gaps);
        int unsigned total;
        int unsigned n;
        int unsigned exp_sum;
        int unsigned exp_ovf;
        int unsigned exp_cnt;
        total = 0;
        n = burst_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_valid = 1'b0;
                i_data  = WIDTH'($urandom);
                i_last  = 1'($urandom);
                @(posedge i_clk);
                @(negedge i_clk);
            end
            i_valid = 1'b1;
            i_data  = WIDTH'(burst_q[i]);
            i_last  = (i == n - 1);
            total  += burst_q[i];
            check("o_ready_beat", 32'(o_ready), 32'd1);
            check("o_valid_beat", 32'(o_valid), 32'd0);
            @(posedge i_clk);
            @(negedge i_clk);
        end
        exp_sum = total % SUM_MOD;
        exp_ovf = (total >= SUM_MOD) ? 1 : 0;
        exp_cnt = (n > CNT_MAX) ? CNT_MAX : n;
        if (next_beat >= 0) begin
            i_valid = 1'b1;
            i_data  = WIDTH'(next_beat);
            i_last  = 1'b1;
        end else begin
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
        check("o_valid_result", 32'(o_valid), 32'd1);
        check("o_sum", 32'(o_sum), exp_sum);
        check("o_overflow", 32'(o_overflow), exp_ovf);
        check("o_count", 32'(o_count), exp_cnt);
        check("o_ready_hold", 32'(o_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("o_valid_stall", 32'(o_valid), 32'd1);
            check("o_sum_stall", 32'(o_sum), exp_sum);
            check("o_ready_stall", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        check("o_valid_release", 32'(o_valid), 32'd0);
        check("o_ready_release", 32'(o_ready), 32'd1);
        check("o_sum_retained", 32'(o_sum), exp_sum);
        check("o_count_retained", 32'(o_count), exp_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge i_clk);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_sum", 32'(o_sum), 32'd0);
        check("rst_o_count", 32'(o_count), 32'd0);
        check("rst_o_overflow", 32'(o_overflow), 32'd0);
        i_rst_n = 1'b1;
        check("rst_o_ready", 32'(o_ready), 32'd1);

        burst_q = '{7, 7, 7, 7};
        run_burst(0, -1, 1'b0);
        burst_q = '{7, 7, 7, 7, 7};
        run_burst(1, -1, 1'b0);
        burst_q = '{2, 3};
        run_burst(0, -1, 1'b0);
        burst_q = '{5};
        run_burst(0, -1, 1'b0);

        // Upstream waits with 6 during a 3-cycle stall; it must enter as a fresh burst.
        burst_q = '{3, 2};
        run_burst(3, 6, 1'b0);
        burst_q = '{6};
        run_burst(0, -1, 1'b0);

        // Reset in the middle of a burst discards the partial sum.
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1;
            i_data  = WIDTH'(4);
            i_last  = 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("midrst_o_valid", 32'(o_valid), 32'd0);
        check("midrst_o_sum", 32'(o_sum), 32'd0);
        check("midrst_o_count", 32'(o_count), 32'd0);
        check("midrst_o_overflow", 32'(o_overflow), 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("midrst_o_ready", 32'(o_ready), 32'd1);
        burst_q = '{1};
        run_burst(0, -1, 1'b0);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                burst_q = '{a, b};
                run_burst(0, -1, 1'b0);
            end
        end

        // Random lengths past the counter limit, random gaps and random stalls.
        for (int t = 0; t < 40; t++) begin
            int unsigned len;
            len = $urandom_range(1, 20);
            burst_q = {};
            for (int i = 0; i < len; i++) begin
                burst_q.push_back($urandom_range(0, 7));
            end
            run_burst(int'($urandom_range(0, 3)), -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
